data_mem_responder: RTL

//  Memory-side responder for the CPU data port. It accepts load/store requests,

---
 rtl/mem_if_pkg.sv | 15 +
 rtl/bw_ram.sv | 26 ++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared encodings for the data-memory responder: FSM states, strobe constant, counter width.
// No logic, so no latency. No flow control.
// Types only; the responder and the testbench import it.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WSTRB_ALL = 4'hF;
    localparam int         CNT_W     = 4;

endpackage

// File: rtl/bw_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Latency: read data appears one clock after the address is presented.
// Backpressure: none; it accepts an access every cycle.
module bw_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Read-first: a write and a read in the same cycle return the old word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder: byte-strobed stores and word loads on an internal RAM.
// Latency: mem_ready WAIT_CYCLES+1 cycles after the request is accepted.
// Backpressure: mem_stall = mem_en & ~mem_ready; only one request in flight.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_stall
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam bit               NO_WAIT   = (WAIT_CYCLES == 0);

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt;
    logic                    wr_q, err_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q, rdata_q;
    logic [3:0]              wstrb_q;

    logic                    accept, go, in_err;
    logic                    sel_wr, sel_err;
    logic [ADDR_WIDTH-1:0]   sel_idx;
    logic [31:0]             sel_wdata, ram_rdata, resp_rdata;
    logic [3:0]              sel_wstrb, ram_we;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^mem_addr[1:0];

    assign in_err = |mem_addr[31:ADDR_WIDTH+2];
    assign accept = (state == IDLE) && mem_en;

    // With no wait states the RAM is accessed on the accepting edge, before the
    // latches hold the request, so the live inputs are steered to the RAM in IDLE.
    assign sel_wr    = (state == IDLE) ? mem_wr                      : wr_q;
    assign sel_err   = (state == IDLE) ? in_err                      : err_q;
    assign sel_idx   = (state == IDLE) ? mem_addr[ADDR_WIDTH+1:2]    : idx_q;
    assign sel_wdata = (state == IDLE) ? mem_wdata                   : wdata_q;
    assign sel_wstrb = (state == IDLE) ? mem_wstrb                   : wstrb_q;

    assign ram_we = (go && sel_wr && !sel_err) ? sel_wstrb : 4'h0;

    bw_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (sel_idx),
        .wdata (sel_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state;
        go      = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_en) begin
                    if (NO_WAIT) begin
                        state_d = RESP;
                        go      = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_d = RESP;
                    go      = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp_rdata = err_q ? 32'h0 : (wr_q ? rdata_q : ram_rdata);

    assign mem_ready = (state == RESP);
    assign mem_err   = mem_ready && err_q;
    assign mem_rdata = mem_ready ? resp_rdata : rdata_q;
    assign mem_stall = mem_en & ~mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                cnt     <= WAIT_INIT;
                wr_q    <= mem_wr;
                err_q   <= in_err;
                idx_q   <= mem_addr[ADDR_WIDTH+1:2];
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == RESP) begin
                rdata_q <= resp_rdata;
            end
        end
    end

endmodule
